keypad_scanner: RTL and testbench

- Scans the front-panel 4x4 hex key matrix and debounces it.
- Produces one-clock press pulses for keys 0x0-0xF, which feed the b_0..b_f inputs of the UI control stage directly downstream.
- Drives the matrix rows, samples the columns, and reports only clean, debounced press edges.

---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex key matrix scanner with debouncing.
// Drives one row low at a time and samples the columns near the end of each row slot.
// A full-matrix snapshot is produced once per scan. A key change takes effect only
// after DEBOUNCE_SCANS+1 identical snapshots, and newly pressed keys then pulse for one clock.
// Optional feature macro: MULTIKEY_LOCKOUT_EN. When it is defined, snapshots with two or
// more keys down are rejected, which suppresses ghost keys.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] key_pulse,
  output logic        key_down,
  output logic [3:0]  key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] EQ_MAX   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] EQ_ARM   = CW'(DEBOUNCE_SCANS - 1);

  // Two-flop column synchroniser; the pull-ups make all-ones the idle value.
  logic [3:0]    col_p0, col_p1;
  // Row scan state.
  logic [DW-1:0] div;
  logic [1:0]    row;
  logic [11:0]   scan_buf;   // rows 0..2 of the scan in progress
  // Completed snapshot and its strobe (scan_done).
  logic [15:0]   snap_p2;
  logic          vld_p2;
  // Debounce state.
  logic [15:0]   prev_snap;
  logic [15:0]   stable;
  logic [CW-1:0] eq_cnt;
  logic          snap_ok;
  logic          same;
  logic          commit;

  // Saturating increment of the equal-snapshot counter, so a held key never re-arms.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt == EQ_MAX) ? cnt : cnt + CW'(1);
  endfunction

  // Index of the lowest set bit, or 0 when no bit is set.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

`ifdef MULTIKEY_LOCKOUT_EN
  // True when two or more bits are set.
  function automatic logic multi_hot(input logic [15:0] v);
    return |(v & (v - 16'd1));
  endfunction

  assign snap_ok = ~multi_hot(snap_p2);
`else
  assign snap_ok = 1'b1;
`endif

  // Synchronise the asynchronous column inputs before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= col_n;
      col_p1 <= col_p0;
    end
  end

  // Row scan: hold each row for SCAN_DIV clocks, then sample its columns on the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      row      <= 2'd0;
      row_n    <= 4'b1110;
      scan_buf <= '0;
      snap_p2  <= '0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (div == DIV_LAST) begin
        div   <= '0;
        row   <= row + 2'd1;
        row_n <= {row_n[2:0], row_n[3]};
        case (row)
          2'd0: scan_buf[3:0]  <= ~col_p1;
          2'd1: scan_buf[7:4]  <= ~col_p1;
          2'd2: scan_buf[11:8] <= ~col_p1;
          default: begin
            snap_p2 <= {~col_p1, scan_buf};
            vld_p2  <= 1'b1;
          end
        endcase
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  // Compare the new snapshot with the previous one and decide whether the stable state updates.
  always_comb begin
    same   = (snap_p2 == prev_snap);
    commit = vld_p2 && snap_ok && same && (eq_cnt == EQ_ARM);
  end

  // Debounce counter, stable state and registered outputs; pulses only for newly pressed keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_snap <= '0;
      stable    <= '0;
      eq_cnt    <= '0;
      key_pulse <= '0;
      key_down  <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_pulse <= '0;
      if (vld_p2) begin
        if (!snap_ok) begin
          eq_cnt <= '0;
        end else begin
          eq_cnt    <= same ? sat_inc(eq_cnt) : '0;
          prev_snap <= snap_p2;
          if (commit) begin
            stable    <= snap_p2;
            key_pulse <= snap_p2 & ~stable;
            key_down  <= |snap_p2;
            key_code  <= lowest_idx(snap_p2);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_SCANS=2 (16-clock scans).
// A behavioural key matrix pulls a column low while its row is driven and the key is held.
// Each scan window starts just after the debounce edge of the previous scan, so the pulse
// produced by a scan appears on the final edge of its own window.
module tb_keypad_scanner;

`ifdef MULTIKEY_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] key_pulse;
  logic        key_down;
  logic [3:0]  key_code;
  logic [15:0] pressed;

  int tests = 0;
  int fails = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_pulse (key_pulse),
    .key_down  (key_down),
    .key_code  (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix model: column c is low when a driven row r has key 4r+c held.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && pressed[4*r+c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold 'keys' for one full scan, then check the row sequence, the pulse and the key state.
  task automatic scan_chk(input string tag, input logic [15:0] keys, input logic [15:0] exp_pulse,
                          input logic exp_down, input logic [3:0] exp_code);
    int          pulse_cnt;
    logic [15:0] pulse_last;
    logic        row_bad;
    logic [3:0]  exp_row;
    int          m;
    pressed    = keys;
    pulse_cnt  = 0;
    pulse_last = '0;
    row_bad    = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (key_pulse !== 16'h0) pulse_cnt++;
      if (i == 16) pulse_last = key_pulse;
      m       = (i + 1) % 16;
      exp_row = ~(4'b0001 << (m / 4));
      if (row_n !== exp_row) row_bad = 1'b1;
    end
    chk({tag, ".rows"},   {31'd0, row_bad}, 32'd0);
    chk({tag, ".pulse"},  {16'd0, pulse_last}, {16'd0, exp_pulse});
    chk({tag, ".npulse"}, pulse_cnt, (exp_pulse != 16'h0) ? 32'd1 : 32'd0);
    chk({tag, ".down"},   {31'd0, key_down}, {31'd0, exp_down});
    chk({tag, ".code"},   {28'd0, key_code}, {28'd0, exp_code});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    pressed = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset asserted asynchronously in the middle of row 2.
    pressed = 16'h0011;
    repeat (10) @(posedge clk);
    #1;
    chk("t1.row2_before_reset", {28'd0, row_n}, 32'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1.rst_row_n", {28'd0, row_n}, 32'b1110);
    chk("t1.rst_pulse", {16'd0, key_pulse}, 32'd0);
    chk("t1.rst_down",  {31'd0, key_down}, 32'd0);
    chk("t1.rst_code",  {28'd0, key_code}, 32'd0);
    pressed = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("t1.rst_hold_row_n", {28'd0, row_n}, 32'b1110);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t1.first_edge_row_n", {28'd0, row_n}, 32'b1110);
    scan_chk("t1.s1", 16'h0000, 16'h0000, 1'b0, 4'd0);
    scan_chk("t1.s2", 16'h0000, 16'h0000, 1'b0, 4'd0);
    scan_chk("t1.s3", 16'h0000, 16'h0000, 1'b0, 4'd0);

    // 2. Clean press of key 5 held for five scans.
    scan_chk("t2.s1", 16'h0020, 16'h0000, 1'b0, 4'd0);
    scan_chk("t2.s2", 16'h0020, 16'h0000, 1'b0, 4'd0);
    scan_chk("t2.s3", 16'h0020, 16'h0020, 1'b1, 4'd5);
    scan_chk("t2.s4", 16'h0020, 16'h0000, 1'b1, 4'd5);
    scan_chk("t2.s5", 16'h0020, 16'h0000, 1'b1, 4'd5);

    // 4b. Release key 5: key_down falls after three empty scans, no pulse.
    scan_chk("t4b.s1", 16'h0000, 16'h0000, 1'b1, 4'd5);
    scan_chk("t4b.s2", 16'h0000, 16'h0000, 1'b1, 4'd5);
    scan_chk("t4b.s3", 16'h0000, 16'h0000, 1'b0, 4'd0);

    // 3. Bounce on key 9: present, present, absent, then present for three scans.
    scan_chk("t3.s1", 16'h0200, 16'h0000, 1'b0, 4'd0);
    scan_chk("t3.s2", 16'h0200, 16'h0000, 1'b0, 4'd0);
    scan_chk("t3.s3", 16'h0000, 16'h0000, 1'b0, 4'd0);
    scan_chk("t3.s4", 16'h0200, 16'h0000, 1'b0, 4'd0);
    scan_chk("t3.s5", 16'h0200, 16'h0000, 1'b0, 4'd0);
    scan_chk("t3.s6", 16'h0200, 16'h0200, 1'b1, 4'd9);
    scan_chk("t3.r1", 16'h0000, 16'h0000, 1'b1, 4'd9);
    scan_chk("t3.r2", 16'h0000, 16'h0000, 1'b1, 4'd9);
    scan_chk("t3.r3", 16'h0000, 16'h0000, 1'b0, 4'd0);

    // 4a. Key F held for only two scans: never accepted.
    scan_chk("t4a.s1", 16'h8000, 16'h0000, 1'b0, 4'd0);
    scan_chk("t4a.s2", 16'h8000, 16'h0000, 1'b0, 4'd0);
    scan_chk("t4a.s3", 16'h0000, 16'h0000, 1'b0, 4'd0);
    scan_chk("t4a.s4", 16'h0000, 16'h0000, 1'b0, 4'd0);
    scan_chk("t4a.s5", 16'h0000, 16'h0000, 1'b0, 4'd0);

    // Key C pressed while key A is held pulses only C (lockout rejects the pair).
    scan_chk("tac.a1", 16'h0400, 16'h0000, 1'b0, 4'd0);
    scan_chk("tac.a2", 16'h0400, 16'h0000, 1'b0, 4'd0);
    scan_chk("tac.a3", 16'h0400, 16'h0400, 1'b1, 4'd10);
    scan_chk("tac.c1", 16'h1400, 16'h0000, 1'b1, 4'd10);
    scan_chk("tac.c2", 16'h1400, 16'h0000, 1'b1, 4'd10);
    scan_chk("tac.c3", 16'h1400, LOCK ? 16'h0000 : 16'h1000, 1'b1, 4'd10);
    scan_chk("tac.r1", 16'h0000, 16'h0000, 1'b1, 4'd10);
    scan_chk("tac.r2", 16'h0000, 16'h0000, 1'b1, 4'd10);
    scan_chk("tac.r3", 16'h0000, 16'h0000, 1'b0, 4'd0);

    // 5/6. Keys 3 and C together for four scans, then C released with 3 held.
    scan_chk("t5.s1", 16'h1008, 16'h0000, 1'b0, 4'd0);
    scan_chk("t5.s2", 16'h1008, 16'h0000, 1'b0, 4'd0);
    scan_chk("t5.s3", 16'h1008, LOCK ? 16'h0000 : 16'h1008, !LOCK, LOCK ? 4'd0 : 4'd3);
    scan_chk("t5.s4", 16'h1008, 16'h0000, !LOCK, LOCK ? 4'd0 : 4'd3);
    scan_chk("t6.s1", 16'h0008, 16'h0000, !LOCK, LOCK ? 4'd0 : 4'd3);
    scan_chk("t6.s2", 16'h0008, 16'h0000, !LOCK, LOCK ? 4'd0 : 4'd3);
    scan_chk("t6.s3", 16'h0008, LOCK ? 16'h0008 : 16'h0000, 1'b1, 4'd3);
    scan_chk("t6.r1", 16'h0000, 16'h0000, 1'b1, 4'd3);
    scan_chk("t6.r2", 16'h0000, 16'h0000, 1'b1, 4'd3);
    scan_chk("t6.r3", 16'h0000, 16'h0000, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
